// File: rtl/cond_flag_unit.sv
// Condition evaluation, NZCV flag register and write-strobe gating, with an optional MUL/DIV stall/commit sequencer.
// Optional feature macro: MCYCLE_EN (multicycle FSM, Start/Done handshake, Stall).
module cond_flag_unit (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Start,
    input  logic       Done,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       C_in,
    output logic [3:0] Flags,
    output logic       Stall
);

    logic [3:0] flags_q;
    logic       cond_pass;
    logic [1:0] flag_we;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign Flags = flags_q;
    assign C_in  = flags_q[1];

    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

`ifdef MCYCLE_EN
    typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

    state_t     state, next_state;
    logic [1:0] flagw_lat;
    logic       regw_lat;
    logic       issue;

    assign issue = (state == IDLE) && Start && cond_pass;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            flagw_lat <= 2'b00;
            regw_lat  <= 1'b0;
        end else begin
            state <= next_state;
            if (issue) begin
                flagw_lat <= FlagW;
                regw_lat  <= RegW && !NoWrite;
            end
        end
    end

    always_comb begin
        next_state = state;
        CondEx     = cond_pass;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Stall      = 1'b0;
        flag_we    = 2'b00;
        case (state)
            IDLE: begin
                PCSrc    = PCS && cond_pass;
                RegWrite = RegW && cond_pass && !NoWrite;
                MemWrite = MemW && cond_pass && !Start;
                // The multicycle unit owns the flags until its COMMIT cycle.
                if (Start && cond_pass)
                    next_state = EXEC;
                else
                    flag_we = FlagW & {2{cond_pass}};
            end
            EXEC: begin
                CondEx = 1'b1;
                Stall  = 1'b1;
                if (Done)
                    next_state = COMMIT;
            end
            COMMIT: begin
                CondEx     = 1'b1;
                RegWrite   = regw_lat;
                flag_we    = flagw_lat;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
`else
    logic unused_mcycle;
    assign unused_mcycle = ^{Start, Done};

    assign CondEx   = cond_pass;
    assign PCSrc    = PCS && cond_pass;
    assign RegWrite = RegW && cond_pass && !NoWrite;
    assign MemWrite = MemW && cond_pass;
    assign Stall    = 1'b0;
    assign flag_we  = FlagW & {2{cond_pass}};
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            flags_q <= 4'b0000;
        end else begin
            if (flag_we[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_we[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed-vector bench for cond_flag_unit; multicycle scenarios build only with MCYCLE_EN.
module tb_cond_flag_unit;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, Start, Done;
    logic       PCSrc, RegWrite, MemWrite, CondEx, C_in, Stall;
    logic [3:0] Flags;

    int vecs = 0;
    int errs = 0;

    cond_flag_unit dut (
        .CLK(CLK), .RESETn(RESETn), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Start(Start), .Done(Done),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .C_in(C_in), .Flags(Flags), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Start = 1'b0; Done = 1'b0;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        quiet_inputs();
        Cond = 4'b0000;
        #3;
        vecs++; if (Flags !== 4'b0000) begin errs++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        vecs++; if (C_in !== 1'b0) begin errs++; $display("FAIL reset_cin got=%b exp=0", C_in); end
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        vecs++; if (CondEx !== 1'b0) begin errs++; $display("FAIL reset_eq got=%b exp=0", CondEx); end
        step();
        RESETn = 1'b1;
        Cond = 4'b1110; #1;
        vecs++; if (CondEx !== 1'b1) begin errs++; $display("FAIL reset_al got=%b exp=1", CondEx); end
        Cond = 4'b1111; #1;
        vecs++; if (CondEx !== 1'b0) begin errs++; $display("FAIL reset_nv got=%b exp=0", CondEx); end
        Cond = 4'b0001; #1;
        vecs++; if (CondEx !== 1'b1) begin errs++; $display("FAIL reset_ne got=%b exp=1", CondEx); end
    endtask

    task automatic test_cmp_equal();
        step();
        quiet_inputs();
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
        #1;
        vecs++; if (Flags !== 4'b0000) begin errs++; $display("FAIL no_bypass got=%b exp=0000", Flags); end
        step();
        FlagW = 2'b00; ALUFlags = 4'b0000;
        Cond = 4'b0000; RegW = 1'b1; #1;
        vecs++; if (Flags !== 4'b0100) begin errs++; $display("FAIL cmp_flags got=%b exp=0100", Flags); end
        vecs++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL eq_regwrite got=%b exp=1", RegWrite); end
        Cond = 4'b0001; #1;
        vecs++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL ne_regwrite got=%b exp=0", RegWrite); end
    endtask

    task automatic test_group_write();
        step();
        quiet_inputs();
        ALUFlags = 4'b1011; FlagW = 2'b10;
        step();
        #1;
        vecs++; if (Flags !== 4'b1000) begin errs++; $display("FAIL nz_only got=%b exp=1000", Flags); end
        ALUFlags = 4'b0011; FlagW = 2'b01;
        step();
        #1;
        vecs++; if (Flags !== 4'b1011) begin errs++; $display("FAIL cv_only got=%b exp=1011", Flags); end
        vecs++; if (C_in !== 1'b1) begin errs++; $display("FAIL cin got=%b exp=1", C_in); end
        Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b0000;
        step();
        #1;
        vecs++; if (Flags !== 4'b1011) begin errs++; $display("FAIL failed_cond_hold got=%b exp=1011", Flags); end
    endtask

    task automatic test_signed_conds();
        logic [3:0] codes [6];
        logic       exp   [6];
        step();
        quiet_inputs();
        ALUFlags = 4'b1000; FlagW = 2'b11;
        step();
        quiet_inputs();
        #1;
        // N=1 Z=0 C=0 V=0
        codes = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b1001};
        exp   = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
        for (int i = 0; i < 6; i++) begin
            Cond = codes[i]; #1;
            vecs++;
            if (CondEx !== exp[i]) begin
                errs++; $display("FAIL signed_cond cond=%b got=%b exp=%b", codes[i], CondEx, exp[i]);
            end
        end
        Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1; PCS = 1'b1; MemW = 1'b1; #1;
        vecs++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL nowrite got=%b exp=0", RegWrite); end
        vecs++; if (PCSrc !== 1'b1) begin errs++; $display("FAIL pcsrc got=%b exp=1", PCSrc); end
        vecs++; if (MemWrite !== 1'b1) begin errs++; $display("FAIL memwrite got=%b exp=1", MemWrite); end
    endtask

`ifdef MCYCLE_EN
    task automatic test_multicycle();
        step();
        quiet_inputs();
        // Flags are 1000 entering; issue cycle must not write them.
        Start = 1'b1; FlagW = 2'b11; RegW = 1'b1; ALUFlags = 4'b0110;
        step();
        Start = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            Done = (i == 2);
            #1;
            vecs++; if (Stall !== 1'b1) begin errs++; $display("FAIL exec_stall cyc=%0d got=%b exp=1", i, Stall); end
            vecs++; if ({RegWrite, PCSrc, MemWrite} !== 3'b000) begin
                errs++; $display("FAIL exec_writes cyc=%0d got=%b exp=000", i, {RegWrite, PCSrc, MemWrite});
            end
            vecs++; if (Flags !== 4'b1000) begin errs++; $display("FAIL exec_flags cyc=%0d got=%b exp=1000", i, Flags); end
            step();
        end
        quiet_inputs();
        Done = 1'b1; ALUFlags = 4'b0101; #1;
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL commit_stall got=%b exp=0", Stall); end
        vecs++; if (RegWrite !== 1'b1) begin errs++; $display("FAIL commit_regwrite got=%b exp=1", RegWrite); end
        step();
        quiet_inputs();
        Cond = 4'b0000; #1;
        vecs++; if (Flags !== 4'b0101) begin errs++; $display("FAIL commit_flags got=%b exp=0101", Flags); end
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL post_commit_stall got=%b exp=0", Stall); end
        vecs++; if (CondEx !== 1'b1) begin errs++; $display("FAIL post_commit_eq got=%b exp=1", CondEx); end
    endtask

    task automatic test_skip();
        step();
        quiet_inputs();
        Cond = 4'b0001; Start = 1'b1; FlagW = 2'b11; RegW = 1'b1; MemW = 1'b1; ALUFlags = 4'b1111;
        #1;
        vecs++; if ({Stall, RegWrite, MemWrite} !== 3'b000) begin
            errs++; $display("FAIL skip_issue got=%b exp=000", {Stall, RegWrite, MemWrite});
        end
        step();
        quiet_inputs();
        #1;
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL skip_stall got=%b exp=0", Stall); end
        vecs++; if (Flags !== 4'b0101) begin errs++; $display("FAIL skip_flags got=%b exp=0101", Flags); end
    endtask

    task automatic test_reset_mid_exec();
        step();
        quiet_inputs();
        Start = 1'b1; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
        step();
        quiet_inputs();
        #1;
        vecs++; if (Stall !== 1'b1) begin errs++; $display("FAIL rst_exec_stall got=%b exp=1", Stall); end
        step();
        Done = 1'b1; RESETn = 1'b0; #1;
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", Stall); end
        vecs++; if (Flags !== 4'b0000) begin errs++; $display("FAIL rst_flags got=%b exp=0000", Flags); end
        vecs++; if (RegWrite !== 1'b0) begin errs++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite); end
        step();
        RESETn = 1'b1;
        step();
        #1;
        vecs++; if ({Stall, RegWrite, Flags} !== 6'b000000) begin
            errs++; $display("FAIL rst_after got=%b exp=000000", {Stall, RegWrite, Flags});
        end
    endtask
`else
    task automatic test_no_mcycle();
        step();
        quiet_inputs();
        Start = 1'b1; Done = 1'b1; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1010; #1;
        vecs++; if (MemWrite !== 1'b1) begin errs++; $display("FAIL nomc_memwrite got=%b exp=1", MemWrite); end
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL nomc_stall got=%b exp=0", Stall); end
        step();
        #1;
        vecs++; if (Flags !== 4'b1010) begin errs++; $display("FAIL nomc_flags got=%b exp=1010", Flags); end
        vecs++; if (Stall !== 1'b0) begin errs++; $display("FAIL nomc_stall2 got=%b exp=0", Stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_cmp_equal();
        test_group_write();
        test_signed_conds();
`ifdef MCYCLE_EN
        test_multicycle();
        test_skip();
        test_reset_mid_exec();
`else
        test_no_mcycle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Conditional-execution and flag-state block for the single-issue ARM datapath. It sits on the consumer end of the ALU's flag interface.
- It registers the ALU's {N,Z,C,V} flag outputs (ALUFlags) under per-group write enables.
- It evaluates the instruction's 4-bit condition field against the stored flags and gates the architectural write strobes (PC, register file, memory).
- It returns the stored carry to the ALU as C_in for ADC/SBC/RSC.
- It sequences multicycle operations (MUL/DIV unit) with a stall/commit handshake.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state on rising edge
- RESETn  in  1  asynchronous, active-low reset
- Cond  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU (or multicycle unit during COMMIT)
- FlagW  in  2  [1]=write N,Z; [0]=write C,V
- PCS  in  1  decoder: instruction writes PC
- RegW  in  1  decoder: instruction writes register
- MemW  in  1  decoder: instruction writes memory
- NoWrite  in  1  decoder: compare/test, suppress RegWrite
- Start  in  1  decoder: instruction is multicycle (MUL/DIV)
- Done  in  1  multicycle unit: result and flags valid this cycle
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- CondEx  out  1  condition passed
- C_in  out  1  stored carry to ALU (= Flags[1])
- Flags  out  4  stored {N,Z,C,V}
- Stall  out  1  hold PC/IF stage

## Operation
Condition decode (combinational on stored Flags):
- EQ 0000 → Z; NE 0001 → !Z
- CS 0010 → C; CC 0011 → !C
- MI 0100 → N; PL 0101 → !N
- VS 0110 → V; VC 0111 → !V
- HI 1000 → C&!Z; LS 1001 → !C|Z
- GE 1010 → N==V; LT 1011 → N!=V
- GT 1100 → !Z&(N==V); LE 1101 → Z|(N!=V)
- AL 1110 → 1; 1111 → 0 (NV, never executes)

Flag write:
- N,Z load ALUFlags[3:2] when FlagW[1]&CondEx.
- C,V load ALUFlags[1:0] when FlagW[0]&CondEx.
- Groups are independent. Unwritten flags hold.

FSM states:
- IDLE
  - PCSrc=PCS&CondEx; RegWrite=RegW&CondEx&!NoWrite; MemWrite=MemW&CondEx&!Start.
  - Start&CondEx → EXEC. Latch FlagW, RegW&!NoWrite. No flag write in this cycle.
  - Start&!CondEx → stay IDLE; instruction is skipped, no stall.
- EXEC
  - Stall=1; PCSrc=RegWrite=MemWrite=0; CondEx=1.
  - Start is ignored. Flags hold.
  - Done → COMMIT.
- COMMIT (exactly one cycle)
  - Stall=0; RegWrite=latched RegW; PCSrc=MemWrite=0.
  - Flags updated at end of cycle from ALUFlags per latched FlagW.
  - → IDLE.

## Timing
- Reset values: Flags=4'b0000, C_in=0, state=IDLE, latches cleared, Stall=0.
  - With Flags=0 after reset, CondEx follows Cond: EQ=0, NE=1, AL=1.
- Reset asserted in EXEC/COMMIT: return to IDLE immediately. No flag write, no RegWrite.
- Single-cycle instruction: flag update is visible to the next instruction's CondEx one cycle later. No bypass.
- Multicycle latency: issue cycle + N EXEC cycles (N ≥ 1; the Done-sampled cycle counts) + 1 COMMIT cycle.
  - Done is sampled only in EXEC. Done in IDLE/COMMIT is ignored.
- Gated outputs, CondEx, C_in and Stall are combinational from state, Flags and inputs. No output register.

## Configuration
- MCYCLE_EN defined:
  - FSM, Start/Done handshake and Stall are implemented as above.
- MCYCLE_EN undefined:
  - Block stays permanently in IDLE behaviour. Start and Done are ignored; Stall is tied 0.
  - MemWrite=MemW&CondEx, without the !Start term.
  - Flag/condition logic is unchanged.

## Test plan
- Reset then Cond=0000 (EQ): CondEx=0, Flags=0000, C_in=0. Cond=1110: CondEx=1. Cond=1111: CondEx=0.
- ALUFlags=0100, FlagW=11, Cond=AL (CMP equal): next cycle Flags=0100. Cond=0000, RegW=1 → RegWrite=1. Cond=0001 → RegWrite=0.
- Flags=0100, ALUFlags=1011, FlagW=10: Flags becomes 1000 (C,V hold 00). Then FlagW=01, ALUFlags=0011 → Flags=1011, C_in=1.
- Flags with N=1,V=0: Cond GE → 0, LT → 1, GT → 0, LE → 1. NoWrite=1, RegW=1, CondEx=1 → RegWrite=0.
- Start=1, CondEx=1, FlagW=11, RegW=1; Done after 3 EXEC cycles:
  - Stall=1 for 3 cycles, RegWrite=0 throughout EXEC.
  - COMMIT cycle: RegWrite=1, Stall=0. Flags = ALUFlags sampled in COMMIT.
- Start=1 with condition failing → no Stall, no writes. Separately, RESETn pulsed mid-EXEC → IDLE, Flags=0000, no RegWrite pulse.
